logic_unit_scheduler: RTL

- Shares one registered WIDTH-bit bitwise logic unit among N_REQ requesters.
- The unit provides the team's seven standard gate functions: AND, OR, NOT, NAND, NOR, XOR and XNOR.
- A round-robin arbiter grants one requester at a time through a valid/ready handshake.
- The block sequences the operation and holds the result in a single-entry output buffer until the consumer accepts it.
- It sits between the gate datapath and the control logic that issues bitwise operations.

---
 rtl/logic_unit_scheduler.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/logic_unit_scheduler.sv
// Purpose : round-robin sharing of one registered WIDTH-bit bitwise logic unit among N_REQ requesters.
// Latency : grant/handshake in cycle T -> res_valid from T+2; best case one result every 3 cycles.
// Backpr. : result held in a single-entry buffer (HOLD) until res_ready; no grants are issued meanwhile.
//
// Ports:
//   clk, rst_n                 clock (rising edge) and async active-low reset
//   req_valid/req_ready        per-requester handshake; req_ready is one-hot or zero, only in IDLE
//   req_op/req_a/req_b         per-requester opcode (3b) and operands, slice i belongs to requester i
//   res_valid/res_ready        result handshake
//   res_data/res_id/res_err    result, owning requester, illegal-opcode flag
//   busy, op_count             FSM not idle; saturating count of completed results
module logic_unit_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [3*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_data,
  output logic [IDW-1:0]         res_id,
  output logic                   res_err,
  output logic                   busy,
  output logic [15:0]            op_count
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [IDW-1:0]   r_rr_ptr;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDW-1:0]   r_gid;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_data;
  logic [IDW-1:0]   r_res_id;
  logic             r_res_err;
  logic [15:0]      r_op_count;

  logic             w_any;
  logic             w_hi_any;
  logic [IDW-1:0]   w_lo_idx;
  logic [IDW-1:0]   w_hi_idx;
  logic [IDW-1:0]   w_gidx;
  logic [N_REQ-1:0] w_grant;
  logic             w_hs;
  logic [2:0]       w_sel_op;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [WIDTH-1:0] w_result;

  // Round-robin search: the loop runs high-to-low so the final assignment is the
  // lowest index. Prefer the lowest valid at or above rr_ptr, else wrap to the
  // lowest valid overall.
  always_comb begin
    w_any    = 1'b0;
    w_hi_any = 1'b0;
    w_lo_idx = '0;
    w_hi_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_any    = 1'b1;
        w_lo_idx = IDW'(i);
        if (IDW'(i) >= r_rr_ptr) begin
          w_hi_any = 1'b1;
          w_hi_idx = IDW'(i);
        end
      end
    end
  end

  assign w_gidx  = w_hi_any ? w_hi_idx : w_lo_idx;
  assign w_grant = w_any ? (N_REQ'(1) << w_gidx) : '0;
  assign w_hs    = (r_state == S_IDLE) && w_any;

  // Grants are also masked while reset is asserted so every output reads zero.
  assign req_ready = (r_state == S_IDLE && rst_n) ? w_grant : '0;

  always_comb begin
    w_sel_op = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDW'(i) == w_gidx) begin
        w_sel_op = req_op[3*i +: 3];
        w_sel_a  = req_a[WIDTH*i +: WIDTH];
        w_sel_b  = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  always_comb begin
    w_result = '0;
    case (r_op)
      3'd0:    w_result = r_a & r_b;
      3'd1:    w_result = r_a | r_b;
      3'd2:    w_result = ~r_a;
      3'd3:    w_result = ~(r_a & r_b);
      3'd4:    w_result = ~(r_a | r_b);
      3'd5:    w_result = r_a ^ r_b;
      3'd6:    w_result = ~(r_a ^ r_b);
      default: w_result = '0;  // opcode 7: illegal, flagged via res_err
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_hs) w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_HOLD;
      S_HOLD:  if (res_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_gid       <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
      r_res_err   <= 1'b0;
      r_op_count  <= '0;
    end else begin
      if (w_hs) begin
        r_op     <= w_sel_op;
        r_a      <= w_sel_a;
        r_b      <= w_sel_b;
        r_gid    <= w_gidx;
        r_rr_ptr <= (w_gidx == IDW'(N_REQ - 1)) ? '0 : w_gidx + 1'b1;
      end
      if (r_state == S_EXEC) begin
        r_res_data  <= w_result;
        r_res_id    <= r_gid;
        r_res_err   <= (r_op == 3'd7);
        r_res_valid <= 1'b1;
      end
      if (r_state == S_HOLD && res_ready) begin
        r_res_valid <= 1'b0;
        if (r_op_count != 16'hFFFF) r_op_count <= r_op_count + 16'd1;
      end
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign res_err   = r_res_err;
  assign busy      = (r_state != S_IDLE);
  assign op_count  = r_op_count;

endmodule
